// File: rtl/clk_ctrl_pkg.sv
// Shared constants, FSM encoding and request legality check for the
// clock-enable controller.
package clk_ctrl_pkg;

    localparam int NCH    = 3;
    localparam int CNT_W  = 27;

    localparam int CH_PIX = 0;
    localparam int CH_KHZ = 1;
    localparam int CH_HZ  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } cfg_state_e;

    function automatic logic cfg_legal(input logic [1:0] sel, input logic [CNT_W-1:0] div);
        return (sel <= 2'(NCH - 1)) && (div != '0);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One enable channel: wrapping counter against a loadable divisor, registered
// tick pulse and a square wave that toggles after each tick.
module tick_channel
    import clk_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(4)
) (
    input  logic             clk_i,
    input  logic             clr_n_i,
    input  logic             run_i,
    input  logic             sync_clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_div_i,
    output logic             wrap_o,
    output logic             tick_o,
    output logic             sq_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    // Last cycle of the current period; the top uses it to time divisor swaps.
    assign wrap_o = run_i && (cnt_q == div_q - CNT_W'(1));

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (sync_clr_i) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            if (load_i) begin
                div_d = load_div_i;
            end
        end else begin
            if (tick_q) begin
                sq_d = ~sq_q;
            end
            if (run_i) begin
                if (wrap_o) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // A load only arrives on the wrap cycle, so the old period has completed.
            if (load_i) begin
                div_d = load_div_i;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            cnt_q  <= '0;
            div_q  <= RST_DIV;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule

// File: rtl/clk_enable_ctrl.sv
// Three-channel clock-enable generator with a handshake for retiming one
// channel's divisor at its next period boundary.
module clk_enable_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned DIV0 = 4,
    parameter int unsigned DIV1 = 100000,
    parameter int unsigned DIV2 = 100000000
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             run,
    input  logic             sync_clr,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq
);

    function automatic logic [CNT_W-1:0] rst_div(input int ch);
        case (ch)
            CH_PIX:  return CNT_W'(DIV0);
            CH_KHZ:  return CNT_W'(DIV1);
            CH_HZ:   return CNT_W'(DIV2);
            default: return CNT_W'(DIV0);
        endcase
    endfunction

    cfg_state_e       state_q, state_d;
    logic [1:0]       pend_sel_q, pend_sel_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [NCH-1:0]   wrap;
    logic [NCH-1:0]   load;

    always_comb begin
        state_d    = state_q;
        pend_sel_d = pend_sel_q;
        pend_div_d = pend_div_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        load       = '0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (cfg_legal(cfg_sel, cfg_div)) begin
                        pend_sel_d = cfg_sel;
                        pend_div_d = cfg_div;
                        state_d    = WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                // sync_clr forces the swap now; otherwise wait for the period boundary.
                for (int i = 0; i < NCH; i++) begin
                    if (pend_sel_q == 2'(i) && (sync_clr || wrap[i])) begin
                        load[i] = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            pend_sel_q <= '0;
            pend_div_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_sel_q <= pend_sel_d;
            pend_div_q <= pend_div_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tick_channel #(
            .RST_DIV(rst_div(g))
        ) u_ch (
            .clk_i      (clk),
            .clr_n_i    (clr_n),
            .run_i      (run),
            .sync_clr_i (sync_clr),
            .load_i     (load[g]),
            .load_div_i (pend_div_q),
            .wrap_o     (wrap[g]),
            .tick_o     (tick[g]),
            .sq_o       (sq[g])
        );
    end

endmodule

// File: tb/tb_clk_enable_ctrl.sv
// Directed bench for clk_enable_ctrl with divisors 4/10/25; cycle numbers
// count rising edges since the first reset release.
module tb_clk_enable_ctrl;

    logic        clk;
    logic        clr_n;
    logic        run;
    logic        sync_clr;
    logic        cfg_valid;
    logic [1:0]  cfg_sel;
    logic [26:0] cfg_div;
    logic        cfg_ready;
    logic        cfg_done;
    logic        cfg_err;
    logic [2:0]  tick;
    logic [2:0]  sq;

    clk_enable_ctrl #(
        .DIV0(4),
        .DIV1(10),
        .DIV2(25)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .run       (run),
        .sync_clr  (sync_clr),
        .cfg_valid (cfg_valid),
        .cfg_sel   (cfg_sel),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .sq        (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 1'b0;
    int   cyc      = 0;
    int   ntick [3] = '{0, 0, 0};
    int   last  [3] = '{0, 0, 0};
    int   gap   [3] = '{0, 0, 0};
    int   sq_last [3] = '{0, 0, 0};
    int   sq_gap  [3] = '{0, 0, 0};
    logic [2:0] sq_prev = 3'b000;
    int   ndone = 0;

    always @(posedge clk) begin
        if (started) cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (tick[i] === 1'b1) begin
                ntick[i] <= ntick[i] + 1;
                gap[i]   <= cyc - last[i];
                last[i]  <= cyc;
            end
            if (sq[i] !== sq_prev[i]) begin
                sq_gap[i]  <= cyc - sq_last[i];
                sq_last[i] <= cyc;
            end
        end
        sq_prev <= sq;
        if (cfg_done === 1'b1) ndone <= ndone + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int   t0 [3];
    int   d0;
    logic [2:0] sq_hold;

    initial begin
        clr_n = 1'b0; run = 1'b0; sync_clr = 1'b0;
        cfg_valid = 1'b0; cfg_sel = 2'd0; cfg_div = 27'd0;

        // Reset values
        repeat (3) begin @(negedge clk); #1; end
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_done",  32'(cfg_done), 0);
        chk("rst_err",   32'(cfg_err), 0);
        chk("rst_tick",  32'(tick), 0);
        chk("rst_sq",    32'(sq), 0);
        run = 1'b1;
        @(negedge clk); #1;
        chk("rst_tick_run", 32'(tick), 0);
        clr_n = 1'b1;
        started = 1'b1;

        // Free-running for 100 clocks
        step_to(100);
        chk("p1_n0", ntick[0], 25);
        chk("p1_n1", ntick[1], 10);
        chk("p1_n2", ntick[2], 4);
        chk("p1_gap0", gap[0], 4);
        chk("p1_gap1", gap[1], 10);
        chk("p1_gap2", gap[2], 25);
        chk("p1_sqhalf1", sq_gap[1], 10);
        chk("p1_sq", 32'(sq), 32'b110);
        chk("p1_ndone", ndone, 0);

        // Retime channel 1 to 3; its next tick is at cycle 110
        d0 = ndone;
        cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_div = 27'd3;
        step_to(106);
        cfg_valid = 1'b0;
        chk("p2_ready106", 32'(cfg_ready), 0);
        step_to(107);
        chk("p2_ready107", 32'(cfg_ready), 0);
        cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 27'd9;
        step_to(108);
        cfg_valid = 1'b0;
        chk("p2_ready108", 32'(cfg_ready), 0);
        step_to(109);
        chk("p2_ready109", 32'(cfg_ready), 0);
        chk("p2_done109", 32'(cfg_done), 0);
        step_to(110);
        chk("p2_ready110", 32'(cfg_ready), 1);
        chk("p2_done110", 32'(cfg_done), 1);
        chk("p2_tick1_110", 32'(tick[1]), 1);
        chk("p2_gap1_old", gap[1], 10);
        step_to(111);
        chk("p2_done111", 32'(cfg_done), 0);
        chk("p2_ready111", 32'(cfg_ready), 1);
        step_to(140);
        chk("p2_ndone", ndone - d0, 1);
        chk("p2_gap1", gap[1], 3);
        chk("p2_last1", last[1], 140);
        chk("p2_gap0", gap[0], 4);
        chk("p2_last0", last[0], 140);
        chk("p2_gap2", gap[2], 25);

        // Illegal requests
        d0 = ndone;
        cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_div = 27'd5;
        step_to(141);
        cfg_valid = 1'b0;
        chk("p3_err_sel", 32'(cfg_err), 1);
        chk("p3_ready_sel", 32'(cfg_ready), 1);
        step_to(142);
        chk("p3_err_clr", 32'(cfg_err), 0);
        cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 27'd0;
        step_to(143);
        cfg_valid = 1'b0;
        chk("p3_err_div", 32'(cfg_err), 1);
        chk("p3_ready_div", 32'(cfg_ready), 1);
        step_to(144);
        chk("p3_err_clr2", 32'(cfg_err), 0);
        step_to(160);
        chk("p3_gap0", gap[0], 4);
        chk("p3_last0", last[0], 160);
        chk("p3_gap1", gap[1], 3);
        chk("p3_last1", last[1], 158);
        chk("p3_last2", last[2], 150);
        chk("p3_ndone", ndone - d0, 0);

        // Pause for 7 clocks mid-count
        step_to(162);
        chk("p4_tick162", 32'(tick), 0);
        sq_hold = sq;
        run = 1'b0;
        for (int k = 163; k <= 169; k++) begin
            step_to(k);
            chk("p4_tick_hold", 32'(tick), 0);
            chk("p4_sq_hold", 32'(sq), 32'(sq_hold));
        end
        run = 1'b1;
        step_to(170);
        chk("p4_tick170", 32'(tick), 0);
        step_to(171);
        chk("p4_last0", last[0], 171);
        chk("p4_gap0", gap[0], 11);
        chk("p4_last1", last[1], 171);
        chk("p4_gap1", gap[1], 10);
        step_to(182);
        chk("p4_last2", last[2], 182);
        chk("p4_gap2", gap[2], 32);

        // Pending request held by run=0, then forced by sync_clr
        step_to(183);
        d0 = ndone;
        run = 1'b0;
        cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_div = 27'd5;
        step_to(184);
        cfg_valid = 1'b0;
        for (int k = 184; k <= 188; k++) begin
            step_to(k);
            chk("p5_ready_wait", 32'(cfg_ready), 0);
        end
        sync_clr = 1'b1;
        step_to(189);
        sync_clr = 1'b0;
        chk("p5_done", 32'(cfg_done), 1);
        chk("p5_ready", 32'(cfg_ready), 1);
        chk("p5_tick", 32'(tick), 0);
        chk("p5_sq", 32'(sq), 0);
        step_to(190);
        chk("p5_done_clr", 32'(cfg_done), 0);
        for (int i = 0; i < 3; i++) t0[i] = ntick[i];
        run = 1'b1;
        step_to(195);
        chk("p5_last0", last[0], 194);
        chk("p5_last1", last[1], 193);
        chk("p5_last2", last[2], 195);
        chk("p5_n2", ntick[2] - t0[2], 1);
        chk("p5_ndone", ndone - d0, 1);

        // Reset while a request is pending
        d0 = ndone;
        cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = 27'd7;
        step_to(196);
        cfg_valid = 1'b0;
        chk("p6_ready_wait", 32'(cfg_ready), 0);
        clr_n = 1'b0;
        step_to(197);
        chk("p6_ready_rst", 32'(cfg_ready), 1);
        chk("p6_tick_rst", 32'(tick), 0);
        chk("p6_done_rst", 32'(cfg_done), 0);
        clr_n = 1'b1;
        step_to(222);
        chk("p6_last0", last[0], 221);
        chk("p6_gap0", gap[0], 4);
        chk("p6_last1", last[1], 217);
        chk("p6_gap1", gap[1], 10);
        chk("p6_last2", last[2], 222);
        chk("p6_ndone", ndone - d0, 0);
        chk("p6_ready", 32'(cfg_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
